// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RISC-V pipeline: tracks EX/MEM
// destinations, produces registered forward selects, load-use stall and branch flush.
module pipeline_hazard_ctrl #(
  parameter int XLEN_REGS   = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   id_valid,
  input  logic [XLEN_REGS-1:0]   id_rs1,
  input  logic [XLEN_REGS-1:0]   id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [XLEN_REGS-1:0]   id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   ex_busy,
  input  logic                   branch_taken,
  output logic [1:0]             forward_rs1,
  output logic [1:0]             forward_rs2,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic                 vld_p1, ex_rw_p1, ex_mr_p1;
  logic [XLEN_REGS-1:0] ex_rd_p1;
  logic                 vld_p2, mem_rw_p2;
  logic [XLEN_REGS-1:0] mem_rd_p2;

  logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
  logic load_use, flush;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  function automatic logic match(input logic v, input logic rw,
                                 input logic [XLEN_REGS-1:0] rd,
                                 input logic [XLEN_REGS-1:0] rs,
                                 input logic uses);
    return v & rw & (rd != '0) & uses & (rd == rs);
  endfunction

  // Nearest producer wins; 2'b11 is never produced.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return 2'b01;
    else if (mem_hit) return 2'b10;
    else              return 2'b00;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign ex_hit_rs1  = match(vld_p1, ex_rw_p1, ex_rd_p1, id_rs1, id_uses_rs1);
  assign ex_hit_rs2  = match(vld_p1, ex_rw_p1, ex_rd_p1, id_rs2, id_uses_rs2);
  assign mem_hit_rs1 = match(vld_p2, mem_rw_p2, mem_rd_p2, id_rs1, id_uses_rs1);
  assign mem_hit_rs2 = match(vld_p2, mem_rw_p2, mem_rd_p2, id_rs2, id_uses_rs2);

  assign load_use    = id_valid & ex_mr_p1 & (ex_hit_rs1 | ex_hit_rs2);
  assign flush       = branch_taken & ~ex_busy;
  assign pc_stall    = ex_busy | (load_use & ~flush);
  assign ifid_stall  = pc_stall;
  assign ifid_flush  = flush;
  assign idex_bubble = ~ex_busy & (flush | load_use);

  // ID -> EX -> MEM slot advance; whole pipeline frozen while ex_busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1      <= 1'b0;
      ex_rd_p1    <= '0;
      ex_rw_p1    <= 1'b0;
      ex_mr_p1    <= 1'b0;
      vld_p2      <= 1'b0;
      mem_rd_p2   <= '0;
      mem_rw_p2   <= 1'b0;
      forward_rs1 <= 2'b00;
      forward_rs2 <= 2'b00;
      stall_count <= '0;
    end else if (!ex_busy) begin
      vld_p2    <= vld_p1;
      mem_rd_p2 <= ex_rd_p1;
      mem_rw_p2 <= ex_rw_p1;
      if (idex_bubble || !id_valid) begin
        vld_p1      <= 1'b0;
        ex_rd_p1    <= '0;
        ex_rw_p1    <= 1'b0;
        ex_mr_p1    <= 1'b0;
        forward_rs1 <= 2'b00;
        forward_rs2 <= 2'b00;
      end else begin
        vld_p1      <= 1'b1;
        ex_rd_p1    <= id_rd;
        ex_rw_p1    <= id_regwrite;
        ex_mr_p1    <= id_memread;
        forward_rs1 <= fwd_sel(ex_hit_rs1, mem_hit_rs1);
        forward_rs2 <= fwd_sel(ex_hit_rs2, mem_hit_rs2);
      end
      if (load_use && !flush)
        stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus randomized traffic
// checked against an instruction-history reference model.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_busy, branch_taken;
  logic [1:0]    forward_rs1, forward_rs2;
  logic          pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.XLEN_REGS(RW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_busy(ex_busy),
    .branch_taken(branch_taken), .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: hist[0] is the instruction now in EX, hist[1] the one in MEM.
  typedef struct { bit v; bit [RW-1:0] rd; bit rw; bit mr; } ins_t;
  ins_t hist[$];
  int   m_f1, m_f2, m_cnt;
  bit   last_stall, last_flush, last_bub;

  function automatic bit writes(ins_t p, bit [RW-1:0] rs, bit uses);
    return p.v && p.rw && p.rd != 0 && uses && p.rd == rs;
  endfunction

  function automatic int nearest(bit [RW-1:0] rs, bit uses);
    for (int d = 0; d < 2; d++)
      if (writes(hist[d], rs, uses)) return d + 1;
    return 0;
  endfunction

  task automatic model_reset();
    ins_t e;
    e = '{0, 0, 0, 0};
    hist.delete();
    hist.push_back(e);
    hist.push_back(e);
    m_f1 = 0; m_f2 = 0; m_cnt = 0;
  endtask

  task automatic step(input bit v, input bit [RW-1:0] rs1, input bit [RW-1:0] rs2,
                      input bit u1, input bit u2, input bit [RW-1:0] rd, input bit rw,
                      input bit mr, input bit busy, input bit br);
    bit   lu, fl, e_stall, e_bub;
    int   n_f1, n_f2;
    ins_t nxt;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; ex_busy = busy; branch_taken = br;
    #1;
    lu      = v && hist[0].mr && (writes(hist[0], rs1, u1) || writes(hist[0], rs2, u2));
    fl      = br && !busy;
    e_stall = busy || (lu && !fl);
    e_bub   = !busy && (fl || lu);
    chk("pc_stall", pc_stall, e_stall);
    chk("ifid_stall", ifid_stall, e_stall);
    chk("ifid_flush", ifid_flush, fl);
    chk("idex_bubble", idex_bubble, e_bub);
    chk("forward_rs1", forward_rs1, m_f1);
    chk("forward_rs2", forward_rs2, m_f2);
    chk("stall_count", stall_count, m_cnt);
    last_stall = pc_stall; last_flush = ifid_flush; last_bub = idex_bubble;
    if (e_bub || !v) begin
      nxt = '{0, 0, 0, 0}; n_f1 = 0; n_f2 = 0;
    end else begin
      nxt = '{1, rd, rw, mr}; n_f1 = nearest(rs1, u1); n_f2 = nearest(rs2, u2);
    end
    @(posedge clk);
    if (!busy) begin
      hist.push_front(nxt);
      void'(hist.pop_back());
      m_f1 = n_f1; m_f2 = n_f2;
      if (lu && !fl && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    {id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread, ex_busy, branch_taken} = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd1", forward_rs1, 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_stall", pc_stall, 0);
    @(negedge clk) reset_n = 1'b1;

    // back-to-back: add x5 ; add x6,x5,x7
    step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    step(1, 5, 7, 1, 1, 6, 1, 0, 0, 0);
    #1 chk("b2b_fwd1", forward_rs1, 1); chk("b2b_fwd2", forward_rs2, 0);
    // distance 2: add x5 ; nop ; sub x8,x5,x5
    step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 5, 1, 1, 8, 1, 0, 0, 0);
    #1 chk("d2_fwd1", forward_rs1, 2); chk("d2_fwd2", forward_rs2, 2);
    // nearest wins: two writers of x5 back to back
    step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    step(1, 5, 0, 1, 0, 9, 1, 0, 0, 0);
    #1 chk("near_fwd1", forward_rs1, 1);
    // load-use: lw x10 ; add x11,x10,x0
    step(1, 1, 0, 1, 0, 10, 1, 1, 0, 0);
    step(1, 10, 0, 1, 1, 11, 1, 0, 0, 0);
    chk("lu_stall", last_stall, 1); chk("lu_bub", last_bub, 1);
    step(1, 10, 0, 1, 1, 11, 1, 0, 0, 0);
    chk("lu_once", last_stall, 0); chk("lu_cnt", stall_count, 1);
    #1 chk("lu_fwd1", forward_rs1, 2);
    // x0 load and unused rs2
    step(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    chk("x0_stall", last_stall, 0);
    step(1, 1, 0, 1, 0, 12, 1, 1, 0, 0);
    step(1, 3, 12, 1, 0, 13, 1, 0, 0, 0);
    chk("unused_stall", last_stall, 0);
    // branch beats load-use
    step(1, 1, 0, 1, 0, 10, 1, 1, 0, 0);
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, 1);
    chk("br_flush", last_flush, 1); chk("br_bub", last_bub, 1); chk("br_stall", last_stall, 0);
    // branch ignored while busy, then freeze with forward_rs1=01
    step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    step(1, 5, 7, 1, 1, 6, 1, 0, 0, 0);
    step(1, 6, 6, 1, 1, 7, 1, 0, 1, 1);
    chk("busy_noflush", last_flush, 0);
    step(1, 6, 6, 1, 1, 7, 1, 0, 1, 0);
    step(1, 6, 6, 1, 1, 7, 1, 0, 1, 0);
    #1 chk("frz_fwd1", forward_rs1, 1); chk("frz_stall", pc_stall, 1);
    // async reset mid-freeze
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("amid_fwd1", forward_rs1, 0);
    chk("amid_cnt", stall_count, 0);
    chk("amid_stall", pc_stall, 1);
    model_reset();
    @(negedge clk) reset_n = 1'b1;

    // randomized traffic over a few registers so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    chk("sat_cnt", stall_count, m_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Tracks destination registers of the instructions in EX and MEM internally.
- Produces registered forward_rs1/forward_rs2 selects for the EX-stage forwarding mux, plus load-use stall, bubble and branch-flush controls.
- Sits beside the ID/EX pipeline register. Its selects drive the ALU operand forwarding mux directly.

Parameters:
- XLEN_REGS, 5, register-index width (32 architectural registers).
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  5  ID source register 1 index.
- id_rs2  in  5  ID source register 2 index.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_rd  in  5  ID destination register index.
- id_regwrite  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- ex_busy  in  1  multicycle EX unit not done; freezes whole pipeline.
- branch_taken  in  1  branch/jump resolved taken in EX.
- forward_rs1  out  2  EX operand-1 select: 00 rs1_data, 01 ex_forward_data, 10 mem_forward_data.
- forward_rs2  out  2  EX operand-2 select, same encoding.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID register.
- ifid_flush  out  1  squash IF/ID contents.
- idex_bubble  out  1  load NOP into ID/EX.
- stall_count  out  STALL_CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Internal state:
  - EX slot {v, rd, rw, mr}, reset all 0.
  - MEM slot {v, rd, rw}, reset all 0.
  - forward_rs1/forward_rs2 registers, reset 00.
  - stall_count, reset 0.
- Async reset clears all state immediately, including mid-stall or mid-flush. Combinational outputs follow from the cleared state (all 0 unless ex_busy/branch_taken are asserted).
- match(slot, rs, uses) = slot.v & slot.rw & (slot.rd != 0) & uses & (slot.rd == rs). x0 is never forwarded or stalled on.
- load_use = id_valid & EX.mr & match(EX, id_rs1, id_uses_rs1) | id_valid & EX.mr & match(EX, id_rs2, id_uses_rs2).
- flush = branch_taken & !ex_busy. branch_taken is ignored while ex_busy.
- Combinational outputs:
  - pc_stall = ifid_stall = ex_busy | (load_use & !flush).
  - ifid_flush = flush.
  - idex_bubble = !ex_busy & (flush | load_use).
- Clock edge with ex_busy=1: all state holds, stall_count included. Selects remain stable for the frozen EX instruction.
- Clock edge with ex_busy=0:
  - MEM slot <= EX slot.
  - If idex_bubble or !id_valid: EX slot <= {0,0,0,0}; forward selects <= 00.
  - Otherwise: EX slot <= {1, id_rd, id_regwrite, id_memread}, and each select is computed from the pre-edge slots:
    - 01 if match(EX, rs, uses) (producer moves to EX/MEM);
    - else 10 if match(MEM, rs, uses) (producer moves to MEM/WB);
    - else 00.
  - The nearest producer wins. 11 is never generated.
- Load-use: one-cycle stall. On the following edge the load has moved to MEM, so the re-evaluated consumer gets select 10.
- Branch flush has priority over load-use: no stall and no stall count. The ID instruction is squashed into a bubble.
- A producer three stages ahead (in WB) is covered by register-file write-before-read; this block issues 00 for it.
- stall_count increments by 1 on each edge where load_use & !flush & !ex_busy, and saturates at all-ones.

Test Plan:
- Back-to-back dependency: add x5 in ID, then add x6,x5,x7 → after second ID→EX edge forward_rs1=01, forward_rs2=00, no stall.
- Distance-2: add x5; nop; sub x8,x5,x5 → forward_rs1=10, forward_rs2=10. Two writers of x5 at distance 1 and 2 → 01 (nearest wins).
- Load-use: lw x10 then add x11,x10,x0 → pc_stall=ifid_stall=idex_bubble=1 for exactly one cycle, stall_count 0→1, then add enters EX with forward_rs1=10.
- x0 and unused operands: lw x0 then add x1,x0,x0 → no stall, selects 00. A consumer with id_uses_rs2=0 whose rs2 matches a load's rd → no stall.
- Branch vs load-use: load in EX, dependent in ID, branch_taken=1 the same cycle → ifid_flush=1, idex_bubble=1, pc_stall=0, stall_count unchanged. branch_taken with ex_busy=1 → ignored.
- ex_busy held 3 cycles with forward_rs1=01 → selects, slots and stall_count frozen, pc_stall=1. Asserting reset_n=0 mid-freeze → selects 00, slots empty, stall_count 0 immediately.
